// File: rtl/regfile_wb.sv
// Writeback stage: selects the MEM/WB result and commits it into a 2^AW-entry register file.
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_wb #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 32
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          En,
    input  logic          wWreg,
    input  logic          wReg2reg,
    input  logic [DW-1:0] wD,
    input  logic [DW-1:0] wC,
    input  logic [AW-1:0] wRd,
    input  logic [AW-1:0] Rs,
    input  logic [AW-1:0] Rt,
    output logic [DW-1:0] Qa,
    output logic [DW-1:0] Qb,
    output logic [DW-1:0] WbData,
    output logic [CW-1:0] WbCnt
);

    localparam int unsigned NReg = 2 ** AW;

    logic [DW-1:0] r_regs [NReg];
    logic [CW-1:0] r_cnt;
    logic          w_we;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;

    assign WbData = wReg2reg ? wD : wC;
    // wWreg/En gate first so an idle stage with X address/data never reaches state.
    assign w_we   = En & wWreg & (wRd != '0);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NReg; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt <= '0;
        end else if (w_we) begin
            r_regs[wRd] <= WbData;
            r_cnt       <= r_cnt + CW'(1);
        end
    end

    assign w_rd_a = (Rs == '0) ? '0 : r_regs[Rs];
    assign w_rd_b = (Rt == '0) ? '0 : r_regs[Rt];
    assign WbCnt  = r_cnt;

`ifdef REGFILE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // w_we already excludes register 0, so no separate Rs/Rt != 0 term is needed.
    assign w_byp_a = w_we & ~Clr & (Rs == wRd);
    assign w_byp_b = w_we & ~Clr & (Rt == wRd);
    assign Qa      = w_byp_a ? WbData : w_rd_a;
    assign Qb      = w_byp_b ? WbData : w_rd_b;
`else
    assign Qa = w_rd_a;
    assign Qb = w_rd_b;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reference model plus expected-value queue, checked by assertions.
// A second instance with CW=4 shares all inputs to exercise counter wrap.
module tb_regfile_wb;

    logic        Clk;
    logic        Clr;
    logic        En;
    logic        wWreg;
    logic        wReg2reg;
    logic [31:0] wD;
    logic [31:0] wC;
    logic [4:0]  wRd;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [31:0] Qa;
    logic [31:0] Qb;
    logic [31:0] WbData;
    logic [31:0] WbCnt;
    logic [31:0] Qa4;
    logic [31:0] Qb4;
    logic [31:0] WbData4;
    logic [3:0]  WbCnt4;

    regfile_wb #(.DW(32), .AW(5), .CW(32)) u_dut (
        .Clk(Clk), .Clr(Clr), .En(En), .wWreg(wWreg), .wReg2reg(wReg2reg),
        .wD(wD), .wC(wC), .wRd(wRd), .Rs(Rs), .Rt(Rt),
        .Qa(Qa), .Qb(Qb), .WbData(WbData), .WbCnt(WbCnt)
    );

    regfile_wb #(.DW(32), .AW(5), .CW(4)) u_dut_cnt4 (
        .Clk(Clk), .Clr(Clr), .En(En), .wWreg(wWreg), .wReg2reg(wReg2reg),
        .wD(wD), .wC(wC), .wRd(wRd), .Rs(Rs), .Rt(Rt),
        .Qa(Qa4), .Qb(Qb4), .WbData(WbData4), .WbCnt(WbCnt4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [31:0] sb_q [$];
    int          n_cmp;
    int          n_err;

    task automatic push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic pop_cmp(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs === exp_v) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    // Drives one clock of stimulus from a negedge, updates the model at the edge, returns at the
    // next negedge with the write request dropped.
    task automatic cycle(input logic clr, input logic en, input logic wreg, input logic sel,
                         input logic [4:0] rd, input logic [31:0] d, input logic [31:0] c);
        Clr = clr; En = en; wWreg = wreg; wReg2reg = sel; wRd = rd; wD = d; wC = c;
        @(posedge Clk);
        if (clr) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 32'h0;
        end else if (en && wreg && rd != 5'd0) begin
            m_regs[rd] = sel ? d : c;
            m_cnt      = m_cnt + 32'd1;
        end
        @(negedge Clk);
        Clr = 1'b0; wWreg = 1'b0; En = 1'b0;
    endtask

    task automatic chk_cnt(input string tag);
        push(m_cnt);
        pop_cmp({tag, "_cnt"}, WbCnt);
        push(m_cnt & 32'hF);
        pop_cmp({tag, "_cnt4"}, {28'h0, WbCnt4});
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            Rs = 5'(i);
            Rt = 5'(31 - i);
            #1;
            push(m_regs[i]);
            pop_cmp({tag, "_qa"}, Qa);
            push(m_regs[31 - i]);
            pop_cmp({tag, "_qb"}, Qb);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_cnt = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        Clr = 1'b1; En = 1'b0; wWreg = 1'b0; wReg2reg = 1'b0;
        wD = '0; wC = '0; wRd = '0; Rs = '0; Rt = '0;
        @(negedge Clk);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        sweep("reset");
        chk_cnt("reset");

        // ALU result path
        push(32'h1234_5678);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h1234_5678);
        Rs = 5'd5; #1;
        pop_cmp("step1_qa", Qa);
        chk_cnt("step1");

        // Memory data path
        push(32'hDEAD_BEEF);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'hDEAD_BEEF, 32'h1234_5678);
        Rt = 5'd6; #1;
        pop_cmp("step2_qb", Qb);
        chk_cnt("step2");

        // Write request to r0 is ignored
        push(32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
        Rs = 5'd0; #1;
        pop_cmp("r0_qa", Qa);
        chk_cnt("r0");

        // Stall
        push(32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'h55);
        Rs = 5'd7; #1;
        pop_cmp("stall_qa", Qa);
        chk_cnt("stall");

        // Clear beats a simultaneous commit
        push(32'h0);
        push(32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'hAA);
        Rs = 5'd9; Rt = 5'd5; #1;
        pop_cmp("clrpri_qa9", Qa);
        pop_cmp("clrpri_qb5", Qb);
        chk_cnt("clrpri");

        // Same-cycle read of the register being written
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h11);
`ifdef REGFILE_BYPASS_EN
        push(32'h77);
        push(32'h77);
`else
        push(32'h11);
        push(32'h11);
`endif
        En = 1'b1; wWreg = 1'b1; wReg2reg = 1'b0; wRd = 5'd3; wC = 32'h77; wD = 32'h0;
        Rs = 5'd3; Rt = 5'd3; #1;
        pop_cmp("same_cyc_qa", Qa);
        pop_cmp("same_cyc_qb", Qb);
        push(32'h77);
        pop_cmp("wbdata", WbData);
        @(posedge Clk);
        m_regs[3] = 32'h77;
        m_cnt     = m_cnt + 32'd1;
        @(negedge Clk);
        wWreg = 1'b0; En = 1'b0;
        #1;
        push(32'h77);
        pop_cmp("after_edge_qa", Qa);
        chk_cnt("same_cyc");

        // Idle stage with unknown address/data must not disturb state
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'bx, 32'hx, 32'hx);
        chk_cnt("xsafe");
        sweep("xsafe");

        // Counter wrap on the CW=4 instance: 17 commits from zero
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 17; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
                  $urandom, $urandom);
        end
        push(32'd1);
        pop_cmp("wrap_cnt4", {28'h0, WbCnt4});
        chk_cnt("wrap");
        sweep("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
